// File: rtl/button_stim_pkg.sv
// Shared types and constants for the button stimulus generator.
package button_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BOUNCE  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LFSR_W = 8;

    // x^8+x^6+x^5+x^4+1 as a right-shift Fibonacci: feedback from bits 0,2,3,4
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'h1D;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

endpackage

// File: rtl/button_stim_gen_bounce_lfsr.sv
// 8-bit right-shifting Fibonacci LFSR supplying bounce bits; reloads seed on reset.
module bounce_lfsr
    import button_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic              bit_out
);

    logic [LFSR_W-1:0] r_lfsr;
    logic              w_feedback;

    assign w_feedback = ^(r_lfsr & LFSR_TAPS);
    assign bit_out    = r_lfsr[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= seed;
        end else if (advance) begin
            r_lfsr <= {w_feedback, r_lfsr[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/button_stim_gen.sv
// Renders each press request as bounce burst, clean hold and clean release on a
// registered button line, tracking the toggle state the downstream FSM must reach.
module button_stim_gen
    import button_stim_pkg::*;
#(
    parameter int unsigned       HOLD_CYCLES    = 4,
    parameter int unsigned       RELEASE_CYCLES = 4,
    parameter int unsigned       MAX_BOUNCE     = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_bounces,
    output logic             button,
    output logic             busy,
    output logic             expected_state,
    output logic [CNT_W-1:0] press_count
);

    localparam int unsigned      BNC_W     = 3;
    localparam logic [BNC_W-1:0] MAX_BNC   = BNC_W'(MAX_BOUNCE);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_button;
    logic             w_button_nxt;
    logic             r_expected;
    logic             w_expected_nxt;
    logic [CNT_W-1:0] r_press_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [BNC_W-1:0] w_bounces;
    logic             w_advance;
    logic             w_lfsr_bit;

    bounce_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (w_advance),
        .seed    (LFSR_SEED),
        .bit_out (w_lfsr_bit)
    );

    assign w_bounces = (req_bounces > MAX_BNC) ? MAX_BNC : req_bounces;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_button      <= 1'b0;
            r_expected    <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_button      <= w_button_nxt;
            r_expected    <= w_expected_nxt;
            r_press_count <= w_count_nxt;
        end
    end

    // r_cnt holds the cycles remaining in the current phase, minus one
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_button_nxt   = 1'b0;
        w_expected_nxt = r_expected;
        w_count_nxt    = r_press_count;
        w_advance      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_bounces != '0) begin
                        w_state_nxt = ST_BOUNCE;
                        w_cnt_nxt   = CNT_W'(w_bounces) - CNT_ONE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = HOLD_LAST;
                    end
                end
            end
            ST_BOUNCE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RELEASE;
                    w_cnt_nxt   = REL_LAST;
                    if (r_press_count != CNT_SAT) begin
                        w_count_nxt = r_press_count + CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Button level is decided by the state being entered; each bounce bit consumed steps the LFSR
        case (w_state_nxt)
            ST_BOUNCE: begin
                w_button_nxt = w_lfsr_bit;
                w_advance    = 1'b1;
            end
            ST_HOLD:   w_button_nxt = 1'b1;
            default:   w_button_nxt = 1'b0;
        endcase

        if ((w_state_nxt == ST_HOLD) && (r_state != ST_HOLD)) begin
            w_expected_nxt = ~r_expected;
        end
    end

    assign req_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign button         = r_button;
    assign expected_state = r_expected;
    assign press_count    = r_press_count;

endmodule

// File: tb/tb_button_stim_gen.sv
// Self-checking bench for button_stim_gen: request table plus scoreboard of expected button levels.
module tb_button_stim_gen;

    localparam int unsigned HOLD = 4;
    localparam int unsigned REL  = 4;
    localparam int unsigned MAXB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_bounces;
    logic       button;
    logic       busy;
    logic       expected_state;
    logic [7:0] press_count;

    int checks   = 0;
    int failures = 0;

    logic       sb_q[$];
    logic [7:0] m_lfsr;
    logic       m_state;
    int         m_count;

    typedef struct {
        logic [2:0] bounces;
        int         exp_len;
        logic       exp_state;
        int         exp_count;
        logic       pulse_busy;
    } vec_t;

    vec_t vecs[4];

    button_stim_gen #(
        .HOLD_CYCLES    (HOLD),
        .RELEASE_CYCLES (REL),
        .MAX_BOUNCE     (MAXB),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_bounces    (req_bounces),
        .button         (button),
        .busy           (busy),
        .expected_state (expected_state),
        .press_count    (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[4], l[7:1]};
    endfunction

    task automatic model_reset();
        m_lfsr  = 8'hA5;
        m_state = 1'b0;
        m_count = 0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = 1'b1;
        req_bounces = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_button", int'(button), 0);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_expected", int'(expected_state), 0);
        chk("rst_count", int'(press_count), 0);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(req_ready), 1);
        model_reset();
    endtask

    // Called at a negedge; returns at the negedge after the edge that reopens req_ready
    task automatic send(input logic [2:0] b, input int exp_len, input logic exp_state,
                        input int exp_count, input logic pulse);
        int guard = 0;
        int n;
        int exp_bit;
        while (!req_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_req", int'(req_ready), 1);
        n = (int'(b) > int'(MAXB)) ? int'(MAXB) : int'(b);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(m_lfsr[0]);
            m_lfsr = lfsr_step(m_lfsr);
        end
        repeat (HOLD) sb_q.push_back(1'b1);
        repeat (REL)  sb_q.push_back(1'b0);
        req_valid   = 1'b1;
        req_bounces = b;
        @(posedge clk);
        for (int k = 0; k < exp_len; k++) begin
            @(negedge clk);
            req_valid   = pulse && (k % 2 == 0);
            req_bounces = 3'd0;
            exp_bit = (sb_q.size() > 0) ? int'(sb_q.pop_front()) : 2;
            chk("button", int'(button), exp_bit);
            chk("busy_in_seq", int'(busy), 1);
        end
        req_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("ready_after_seq", int'(req_ready), 1);
        chk("busy_after_seq", int'(busy), 0);
        m_state = ~m_state;
        m_count = (m_count >= 255) ? 255 : m_count + 1;
        chk("expected_state", int'(expected_state), int'(exp_state));
        chk("press_count", int'(press_count), exp_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_bounces = 3'd0;
        model_reset();

        vecs[0] = '{3'd3, 11, 1'b1, 1, 1'b0};
        vecs[1] = '{3'd0,  8, 1'b0, 2, 1'b0};
        vecs[2] = '{3'd7, 12, 1'b1, 3, 1'b1};
        vecs[3] = '{3'd1,  9, 1'b0, 4, 1'b0};

        do_reset();

        for (int v = 0; v < 4; v++) begin
            send(vecs[v].bounces, vecs[v].exp_len, vecs[v].exp_state,
                 vecs[v].exp_count, vecs[v].pulse_busy);
        end

        // Reset landing in the second HOLD cycle abandons the press entirely
        req_valid   = 1'b1;
        req_bounces = 3'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("int_hold1_button", int'(button), 1);
        chk("int_hold1_expected", int'(expected_state), 1);
        @(negedge clk);
        chk("int_hold2_button", int'(button), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("int_rst_button", int'(button), 0);
        chk("int_rst_ready", int'(req_ready), 1);
        chk("int_rst_expected", int'(expected_state), 0);
        chk("int_rst_count", int'(press_count), 0);
        rst_n = 1'b1;
        model_reset();
        send(3'd1, 9, 1'b1, 1, 1'b0);

        do_reset();
        for (int r = 0; r < 260; r++) begin
            send(3'd0, 8, ~m_state, (m_count >= 255) ? 255 : m_count + 1, 1'b0);
        end
        chk("sat_count", int'(press_count), 255);
        chk("even_expected", int'(expected_state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
